sample_frame_loader: RTL and testbench

SAMPLE_FRAME_LOADER -- requirements
Module: sample_frame_loader

---
 rtl/sample_frame_loader_if.sv | 27 ++
 rtl/sample_frame_loader.sv | 79 +++++++
 tb/tb_sample_frame_loader.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/sample_frame_loader_if.sv
// sample_frame_loader_if: sample input, frame output and control bundle for the frame loader.
// sum_o exists only when FRAME_SUM_EN is defined.
interface sample_frame_loader_if #(
    parameter int N = 4,
    parameter int M = 10
);
    logic [N-1:0] din_i;
    logic         din_valid_i;
    logic         din_ready_o;
    logic         flush_i;
    logic         frame_done_i;
    logic [N-1:0] frame_o [0:M-1];
    logic         frame_valid_o;
    logic [3:0]   count_o;
`ifdef FRAME_SUM_EN
    logic [N+3:0] sum_o;
    modport master (output din_i, din_valid_i, flush_i, frame_done_i,
                    input din_ready_o, frame_o, frame_valid_o, count_o, sum_o);
    modport slave (input din_i, din_valid_i, flush_i, frame_done_i,
                   output din_ready_o, frame_o, frame_valid_o, count_o, sum_o);
`else
    modport master (output din_i, din_valid_i, flush_i, frame_done_i,
                    input din_ready_o, frame_o, frame_valid_o, count_o);
    modport slave (input din_i, din_valid_i, flush_i, frame_done_i,
                   output din_ready_o, frame_o, frame_valid_o, count_o);
`endif
endinterface

// File: rtl/sample_frame_loader.sv
// sample_frame_loader: collects M serial samples into a frame and holds it until the consumer releases it.
// Define FRAME_SUM_EN to add a running sum of the current frame on sum_o.
module sample_frame_loader #(
    parameter int N = 4,
    parameter int M = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    sample_frame_loader_if.slave  bus
);
    typedef enum logic {FILL, HOLD} state_t;

    state_t       state_q, state_d;
    logic [3:0]   count_q, count_d;
    logic [N-1:0] frame_q [0:M-1];
    logic [N-1:0] frame_d [0:M-1];
    logic         accept;
`ifdef FRAME_SUM_EN
    logic [N+3:0] sum_q, sum_d;
`endif

    // Reset is folded in so ready is low the instant rst_i drops.
    assign bus.din_ready_o   = rst_i && (state_q == FILL);
    assign accept            = bus.din_ready_o && bus.din_valid_i;
    assign bus.frame_o       = frame_q;
    assign bus.count_o       = count_q;
    assign bus.frame_valid_o = (state_q == HOLD);
`ifdef FRAME_SUM_EN
    assign bus.sum_o         = sum_q;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        frame_d = frame_q;
`ifdef FRAME_SUM_EN
        sum_d   = sum_q;
`endif
        if (bus.flush_i) begin
            state_d = FILL;
            count_d = '0;
            for (int i = 0; i < M; i++) frame_d[i] = '0;
`ifdef FRAME_SUM_EN
            sum_d   = '0;
`endif
        end else if (state_q == HOLD && bus.frame_done_i) begin
            state_d = FILL;
            count_d = '0;
`ifdef FRAME_SUM_EN
            sum_d   = '0;
`endif
        end else if (accept) begin
            for (int i = 0; i < M; i++) if (count_q == 4'(i)) frame_d[i] = bus.din_i;
            count_d = count_q + 4'd1;
            state_d = (count_q == 4'(M - 1)) ? HOLD : FILL;
`ifdef FRAME_SUM_EN
            sum_d   = sum_q + (N + 4)'(bus.din_i);
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= FILL;
            count_q <= '0;
            for (int i = 0; i < M; i++) frame_q[i] <= '0;
`ifdef FRAME_SUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            frame_q <= frame_d;
`ifdef FRAME_SUM_EN
            sum_q   <= sum_d;
`endif
        end
    end
endmodule

// File: tb/tb_sample_frame_loader.sv
// tb_sample_frame_loader: scoreboard bench; completed frames are queued as driven and checked when frame_valid_o rises.
module tb_sample_frame_loader;
    localparam int N = 4;
    localparam int M = 10;

    typedef struct packed {
        logic [M*N-1:0] f;
        logic [N+3:0]   s;
    } exp_t;

    logic clk = 0;
    logic rst_i = 0;
    always #5 clk = ~clk;

    sample_frame_loader_if #(.N(N), .M(M)) bus();
    sample_frame_loader #(.N(N), .M(M)) dut (.clk_i(clk), .rst_i(rst_i), .bus(bus.slave));

    exp_t         sb[$];
    exp_t         last;
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [N-1:0] m_frame [M];
    int           m_cnt;
    bit           m_hold;
    logic [N-1:0] fill_v [M] = '{4'd9, 4'd3, 4'd7, 4'd1, 4'd8, 4'd2, 4'd6, 4'd0, 4'd5, 4'd4};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_hold = 0;
        foreach (m_frame[i]) m_frame[i] = '0;
    endtask

    task automatic push_frame();
        exp_t e;
        e.f = '0;
        e.s = '0;
        for (int i = 0; i < M; i++) begin
            e.f[i*N +: N] = m_frame[i];
            e.s += (N + 4)'(m_frame[i]);
        end
        sb.push_back(e);
    endtask

    task automatic drive(input logic [N-1:0] d, input bit v, input bit fl = 0, input bit fd = 0);
        bus.din_i = d;
        bus.din_valid_i = v;
        bus.flush_i = fl;
        bus.frame_done_i = fd;
        @(posedge clk);
        #1;
        if (fl) model_reset();
        else if (m_hold && fd) begin
            m_hold = 0;
            m_cnt = 0;
        end else if (!m_hold && v) begin
            m_frame[m_cnt] = d;
            m_cnt++;
            if (m_cnt == M) begin
                m_hold = 1;
                push_frame();
            end
        end
        bus.din_valid_i = 0;
        bus.flush_i = 0;
        bus.frame_done_i = 0;
        check("count", bus.count_o, m_cnt);
    endtask

    task automatic check_frame(input string tag);
        int k = 0;
        while (!bus.frame_valid_o && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, "_valid"}, bus.frame_valid_o, 1);
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_sb: got frame expected none queued", tag);
            return;
        end
        last = sb.pop_front();
        for (int i = 0; i < M; i++)
            check($sformatf("%s_f%0d", tag, i), bus.frame_o[i], last.f[i*N +: N]);
        check({tag, "_count"}, bus.count_o, M);
        check({tag, "_ready"}, bus.din_ready_o, 0);
`ifdef FRAME_SUM_EN
        check({tag, "_sum"}, bus.sum_o, last.s);
`endif
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < M; i++) check($sformatf("%s_f%0d", tag, i), bus.frame_o[i], 0);
        check({tag, "_valid"}, bus.frame_valid_o, 0);
`ifdef FRAME_SUM_EN
        check({tag, "_sum"}, bus.sum_o, 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        bus.din_i = '0;
        bus.din_valid_i = 0;
        bus.flush_i = 0;
        bus.frame_done_i = 0;
        model_reset();
        #12;
        check("rst_count", bus.count_o, 0);
        check("rst_ready", bus.din_ready_o, 0);
        check_zero("rst");
        @(negedge clk);
        rst_i = 1;
        #1;
        check("rel_ready", bus.din_ready_o, 1);

        // Full frame with valid held high.
        for (int i = 0; i < M; i++) begin
            drive(fill_v[i], 1);
            if (i < M - 1) check("fill_early", bus.frame_valid_o, 0);
        end
        check("fill_latency", bus.frame_valid_o, 1);
        check_frame("fill");
`ifdef FRAME_SUM_EN
        check("sum45", bus.sum_o, 45);
`endif

        // Samples offered in HOLD must not disturb the frame.
        repeat (5) drive(4'd15, 1);
        for (int i = 0; i < M; i++) check($sformatf("hold_f%0d", i), bus.frame_o[i], last.f[i*N +: N]);
        check("hold_valid", bus.frame_valid_o, 1);
        drive(4'd0, 0, 0, 1);
        check("rel_ready", bus.din_ready_o, 1);
        check("rel_valid", bus.frame_valid_o, 0);
`ifdef FRAME_SUM_EN
        check("rel_sum", bus.sum_o, 0);
`endif
        drive(4'd11, 1);
        check("rel_f0", bus.frame_o[0], 11);
        check("rel_f1_stale", bus.frame_o[1], 3);

        // Flush against an accept at count 6, then frame_done in FILL.
        for (int i = 1; i <= 5; i++) drive(4'(i), 1);
        check("pre_flush_count", bus.count_o, 6);
        drive(4'd12, 1, 1, 0);
        check_zero("flush");
        drive(4'd2, 1);
        drive(4'd0, 0, 0, 1);
        check("fd_fill_f0", bus.frame_o[0], 2);
        check("fd_fill_ready", bus.din_ready_o, 1);

        // Valid toggling: 10 accepts across 19 cycles.
        drive(4'd0, 0, 1, 0);
        for (int i = 0; i < 19; i++) begin
            drive(fill_v[i/2], (i % 2) == 0);
            if (i < 18) check("gap_early", bus.frame_valid_o, 0);
        end
        check_frame("gap");
        drive(4'd0, 0, 0, 1);

        repeat (M) drive(4'd15, 1);
        check_frame("all15");
`ifdef FRAME_SUM_EN
        check("sum150", bus.sum_o, 150);
`endif

        // Asynchronous reset in the middle of a HOLD cycle.
        #3;
        rst_i = 0;
        #1;
        model_reset();
        check("arst_count", bus.count_o, 0);
        check("arst_ready", bus.din_ready_o, 0);
        check_zero("arst");
        @(posedge clk);
        #1;
        check("arst_ready_hold", bus.din_ready_o, 0);
        #3;
        rst_i = 1;
        #1;
        check("arst_rel_ready", bus.din_ready_o, 1);
        drive(4'd7, 1);
        check("arst_f0", bus.frame_o[0], 7);
        check("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
